src_rr_arbiter: RTL and testbench

SRC_RR_ARBITER -- requirements
Module: src_rr_arbiter

---
 rtl/src_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 32 +++
 rtl/src_rr_arbiter.sv | 108 ++++++++++
 tb/tb_src_rr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/src_arb_pkg.sv
// Shared types and defaults for the source round-robin arbiter.
// req_idx_t is sized for the largest supported requester count (8).
package src_arb_pkg;

    localparam int ARB_WIDTH_DEF = 32;
    localparam int ARB_NREQS_DEF = 4;
    localparam int ARB_NMSGS_DEF = 4;
    localparam int ARB_NREQS_MAX = 8;
    localparam int ARB_IDX_W     = $clog2(ARB_NREQS_MAX);

    typedef logic [ARB_IDX_W-1:0] req_idx_t;

    // Circular successor of a requester index in an n-entry ring.
    function automatic req_idx_t rr_next(req_idx_t idx, int n);
        return (int'(idx) == n - 1) ? '0 : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Circular priority search: lowest requesting index at or above ptr,
// otherwise lowest requesting index overall. Purely combinational.
module rr_picker
    import src_arb_pkg::*;
#(
    parameter int p_nreqs = ARB_NREQS_DEF
) (
    input  logic [p_nreqs-1:0] req,
    input  req_idx_t           ptr,
    output logic [p_nreqs-1:0] gnt,
    output req_idx_t           idx,
    output logic               any
);

    logic [p_nreqs-1:0] hi;
    logic [p_nreqs-1:0] sel;

    always_comb begin
        hi = '0;
        for (int i = 0; i < p_nreqs; i++)
            hi[i] = req[i] && (i >= int'(ptr));
        sel = (|hi) ? hi : req;
        any = |req;
        idx = ptr;
        for (int i = p_nreqs - 1; i >= 0; i--)
            if (sel[i]) idx = req_idx_t'(i);
        gnt = '0;
        for (int i = 0; i < p_nreqs; i++)
            gnt[i] = any && (idx == req_idx_t'(i));
    end

endmodule

// File: rtl/src_rr_arbiter.sv
// Round-robin merge of p_nreqs valid/ready streams into one, stopping after
// p_nreqs*p_nmsgs input transfers. SRC_RR_ARBITER_OUTREG_EN adds an output pipe register.
module src_rr_arbiter
    import src_arb_pkg::*;
#(
    parameter int p_width = ARB_WIDTH_DEF,
    parameter int p_nreqs = ARB_NREQS_DEF,
    parameter int p_nmsgs = ARB_NMSGS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [p_nreqs-1:0]         in_val,
    output logic [p_nreqs-1:0]         in_rdy,
    input  logic [p_nreqs*p_width-1:0] in_msg,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [p_width-1:0]         out_msg,
    output logic [$clog2(p_nreqs)-1:0] out_src,
    output logic                       done
);

    localparam int SRC_W = $clog2(p_nreqs);
    localparam int TOTAL = p_nreqs * p_nmsgs;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [p_width-1:0] msg;
    } out_ent_t;

    req_idx_t           ptr;
    req_idx_t           gidx;
    logic [p_nreqs-1:0] gnt;
    logic               any;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_full;
    logic [p_width-1:0] gmsg;
    logic               can_acc;
    logic               in_xfer;
    logic               held;

    rr_picker #(.p_nreqs(p_nreqs)) u_pick (
        .req (in_val),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    // AND-OR mux on the one-hot grant so unknowns on idle lanes stay out.
    always_comb begin
        gmsg = '0;
        for (int i = 0; i < p_nreqs; i++)
            gmsg = gmsg | (in_msg[i*p_width +: p_width] & {p_width{gnt[i]}});
    end

    assign cnt_full = (cnt == CNT_MAX);
    assign in_rdy   = (reset || cnt_full || !can_acc) ? '0 : gnt;
    assign in_xfer  = |(in_val & in_rdy);

`ifdef SRC_RR_ARBITER_OUTREG_EN
    out_ent_t ent_q;
    logic     ent_vld;

    assign can_acc = !ent_vld || out_rdy;
    assign out_val = ent_vld;
    assign out_msg = ent_q.msg;
    assign out_src = ent_q.src;
    assign held    = ent_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld <= 1'b0;
            ent_q   <= '0;
        end else if (in_xfer) begin
            ent_vld <= 1'b1;
            ent_q   <= '{src: gidx[SRC_W-1:0], msg: gmsg};
        end else if (out_rdy) begin
            ent_vld <= 1'b0;
        end
    end
`else
    // Gated on the count limit rather than done so the output never offers
    // a message that the input side would refuse.
    assign can_acc = out_rdy;
    assign out_val = any && !cnt_full && !reset;
    assign out_msg = gmsg;
    assign out_src = gidx[SRC_W-1:0];
    assign held    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (in_xfer) begin
                ptr <= rr_next(gidx, p_nreqs);
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt_full && !held)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_src_rr_arbiter.sv
// Directed bench for src_rr_arbiter; latency expectations follow SRC_RR_ARBITER_OUTREG_EN.
module tb_src_rr_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int M = 4;
`ifdef SRC_RR_ARBITER_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_val = '0;
    logic [N-1:0]   in_rdy;
    logic [N*W-1:0] in_msg = '0;
    logic           out_val;
    logic           out_rdy = 1'b0;
    logic [W-1:0]   out_msg;
    logic [1:0]     out_src;
    logic           done;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int done_cyc = -1;
    int start = 0;
    int rem [N];
    int seq [N];
    int q_src [$];
    logic [W-1:0] q_msg [$];
    int q_cyc [$];

    always #5 clk = ~clk;

    src_rr_arbiter #(.p_width(W), .p_nreqs(N), .p_nmsgs(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src),
        .done    (done)
    );

    // Source model: requester i offers {i, seq[i]} while it has messages left.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_val[i] = (rem[i] > 0);
            in_msg[i*W +: W] = (rem[i] > 0) ? {16'(i), 16'(seq[i])} : {W{1'bx}};
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = in_val & in_rdy;
        if (out_val && out_rdy) begin
            q_src.push_back(int'(out_src));
            q_msg.push_back(out_msg);
            q_cyc.push_back(cyc);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                seq[i]++;
                rem[i]--;
            end
        drive();
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        q_src.delete();
        q_msg.delete();
        q_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_rdy = 1'b0;
        clear_src();
        drive();
        tick();
        tick();
        reset = 1'b0;
        clear_src();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_src();
        for (int i = 0; i < N; i++) rem[i] = 1;
        out_rdy = 1'b1;
        drive();
        #1;
        tick();
        nvec++;
        if (out_val !== 1'b0) begin nerr++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        nvec++;
        if (in_rdy !== '0) begin nerr++; $display("FAIL reset_in_rdy: got %b want 0000", in_rdy); end
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        clear_src();
        drive();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_round_robin();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = M;
        drive();
        #1;
        start = cyc;
        repeat (22) tick();
        nvec++;
        if (q_src.size() != N*M) begin nerr++; $display("FAIL rr_count: got %0d want %0d", q_src.size(), N*M); end
        for (int j = 0; j < q_src.size() && j < N*M; j++) begin
            nvec++;
            if (q_src[j] != j % N) begin nerr++; $display("FAIL rr_src[%0d]: got %0d want %0d", j, q_src[j], j % N); end
            nvec++;
            if (q_msg[j] !== {16'(j % N), 16'(j / N)}) begin
                nerr++; $display("FAIL rr_msg[%0d]: got %h want %h", j, q_msg[j], {16'(j % N), 16'(j / N)});
            end
            nvec++;
            if (q_cyc[j] != start + LAT + j) begin
                nerr++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", j, q_cyc[j] - start, LAT + j);
            end
        end
        nvec++;
        if (done_cyc != start + 17 + LAT) begin
            nerr++; $display("FAIL rr_done_cycle: got %0d want %0d", done_cyc - start, 17 + LAT);
        end
        // Past the limit further requests must be ignored.
        rem[0] = 1;
        drive();
        #1;
        nvec++;
        if (in_rdy !== '0) begin nerr++; $display("FAIL limit_in_rdy: got %b want 0000", in_rdy); end
        nvec++;
        if (out_val !== 1'b0) begin nerr++; $display("FAIL limit_out_val: got %b want 0", out_val); end
        nvec++;
        if (done !== 1'b1) begin nerr++; $display("FAIL limit_done: got %b want 1", done); end
    endtask

    task automatic test_single_req();
        int exp_src [4] = '{3, 0, 1, 2};
        do_reset();
        out_rdy = 1'b1;
        rem[2] = 1;
        drive();
        in_msg[2*W +: W] = {16'd36, 16'd18};
        #1;
        start = cyc;
        repeat (3) tick();
        nvec++;
        if (q_src.size() != 1) begin
            nerr++; $display("FAIL single_count: got %0d want 1", q_src.size());
        end else begin
            nvec++;
            if (q_msg[0] !== 32'h0024_0012) begin nerr++; $display("FAIL single_msg: got %h want 00240012", q_msg[0]); end
            nvec++;
            if (q_src[0] != 2) begin nerr++; $display("FAIL single_src: got %0d want 2", q_src[0]); end
            nvec++;
            if (q_cyc[0] != start + LAT) begin nerr++; $display("FAIL single_latency: got %0d want %0d", q_cyc[0] - start, LAT); end
        end
        // The pointer sits at 3, so a full request set is served from 3.
        q_src.delete();
        q_msg.delete();
        q_cyc.delete();
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive();
        #1;
        repeat (6) tick();
        nvec++;
        if (q_src.size() != 4) begin
            nerr++; $display("FAIL ptr_count: got %0d want 4", q_src.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                nvec++;
                if (q_src[j] != exp_src[j]) begin nerr++; $display("FAIL ptr_src[%0d]: got %0d want %0d", j, q_src[j], exp_src[j]); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = M;
        drive();
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if (out_val !== 1'b1) begin nerr++; $display("FAIL stall_val[%0d]: got %b want 1", k, out_val); end
            nvec++;
            if (out_src !== 2'd0) begin nerr++; $display("FAIL stall_src[%0d]: got %0d want 0", k, out_src); end
            nvec++;
            if (out_msg !== 32'h0) begin nerr++; $display("FAIL stall_msg[%0d]: got %h want 00000000", k, out_msg); end
            nvec++;
            if (in_rdy !== '0) begin nerr++; $display("FAIL stall_in_rdy[%0d]: got %b want 0000", k, in_rdy); end
            tick();
        end
        nvec++;
        if (q_src.size() != 0) begin nerr++; $display("FAIL stall_no_xfer: got %0d want 0", q_src.size()); end
        out_rdy = 1'b1;
        #1;
        repeat (3) tick();
        nvec++;
        if (q_src.size() < 2) begin
            nerr++; $display("FAIL resume_count: got %0d want >=2", q_src.size());
        end else begin
            nvec++;
            if (q_src[0] != 0 || q_msg[0] !== 32'h0) begin
                nerr++; $display("FAIL resume_first: got %0d/%h want 0/00000000", q_src[0], q_msg[0]);
            end
            nvec++;
            if (q_src[1] != 1 || q_msg[1] !== 32'h0001_0000) begin
                nerr++; $display("FAIL resume_second: got %0d/%h want 1/00010000", q_src[1], q_msg[1]);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = M;
        drive();
        #1;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        nvec++;
        if (out_val !== 1'b0) begin nerr++; $display("FAIL midrst_out_val: got %b want 0", out_val); end
        nvec++;
        if (in_rdy !== '0) begin nerr++; $display("FAIL midrst_in_rdy: got %b want 0000", in_rdy); end
        clear_src();
        for (int i = 0; i < N; i++) rem[i] = M;
        drive();
        reset = 1'b0;
        #1;
        start = cyc;
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL midrst_done_clear: got %b want 0", done); end
        repeat (22) tick();
        nvec++;
        if (q_src.size() != N*M) begin nerr++; $display("FAIL midrst_count: got %0d want %0d", q_src.size(), N*M); end
        nvec++;
        if (q_src.size() == 0 || q_src[0] != 0) begin nerr++; $display("FAIL midrst_first_src: want 0 (queue size %0d)", q_src.size()); end
        nvec++;
        if (done_cyc != start + 17 + LAT) begin
            nerr++; $display("FAIL midrst_done_cycle: got %0d want %0d", done_cyc - start, 17 + LAT);
        end
    endtask

    task automatic test_one_src();
        do_reset();
        out_rdy = 1'b1;
        rem[1] = 5;
        drive();
        #1;
        start = cyc;
        repeat (10) tick();
        nvec++;
        if (q_src.size() != 5) begin nerr++; $display("FAIL one_count: got %0d want 5", q_src.size()); end
        for (int j = 0; j < q_src.size() && j < 5; j++) begin
            nvec++;
            if (q_src[j] != 1 || q_msg[j] !== {16'd1, 16'(j)}) begin
                nerr++; $display("FAIL one_msg[%0d]: got %0d/%h want 1/%h", j, q_src[j], q_msg[j], {16'd1, 16'(j)});
            end
            nvec++;
            if (q_cyc[j] != start + LAT + j) begin
                nerr++; $display("FAIL one_cycle[%0d]: got %0d want %0d", j, q_cyc[j] - start, LAT + j);
            end
        end
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL one_done: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_req();
        test_stall();
        test_reset_midop();
        test_one_src();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
